// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: streams a program in through a ready/valid load port,
// then serves single-cycle registered fetches, flagging reads beyond the loaded program.
module instr_mem_loadable #(
    parameter int                      ROM_SIZE    = 256,
    parameter int                      INSTR_WIDTH = 9,
    parameter int                      ADDR_WIDTH  = $clog2(ROM_SIZE),
    parameter logic [INSTR_WIDTH-1:0]  NOP_WORD    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prog_valid,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   prog_last,
    output logic                   prog_ready,
    input  logic                   reload,
    input  logic                   fetch_en,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic                   addr_err,
    output logic                   loaded,
    output logic [ADDR_WIDTH:0]    prog_count
);

    typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_SIZE - 1);

    state_t                    state_reg;
    state_t                    state_next;
    logic [ADDR_WIDTH-1:0]     wr_ptr_reg;
    logic [ADDR_WIDTH:0]       prog_count_reg;
    logic [INSTR_WIDTH-1:0]    instr_out_reg;
    logic                      instr_valid_reg;
    logic                      addr_err_reg;

    logic [INSTR_WIDTH-1:0]    mem [ROM_SIZE];

    logic accept;
    logic load_done;
    logic do_reload;
    logic fetch_go;
    logic fetch_hit;

    assign accept    = (state_reg == ST_LOAD) && prog_valid;
    // Leave load mode on the tagged last word or when the final slot is written.
    assign load_done = accept && (prog_last || (wr_ptr_reg == LAST_ADDR));
    assign do_reload = (state_reg == ST_RUN) && reload;
    assign fetch_go  = (state_reg == ST_RUN) && fetch_en && !reload;
    assign fetch_hit = {1'b0, fetch_addr} < prog_count_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD: if (load_done) state_next = ST_RUN;
            ST_RUN:  if (reload)    state_next = ST_LOAD;
            default: state_next = ST_LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        prog_ready = 1'b0;
        loaded     = 1'b0;
        case (state_reg)
            ST_LOAD: prog_ready = 1'b1;
            ST_RUN:  loaded     = 1'b1;
            default: prog_ready = 1'b1;
        endcase
    end

    // Write pointer saturates at the last slot so it can never wrap onto word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            prog_count_reg <= '0;
        end else if (do_reload) begin
            wr_ptr_reg     <= '0;
            prog_count_reg <= '0;
        end else if (accept) begin
            prog_count_reg <= prog_count_reg + 1'b1;
            if (wr_ptr_reg != LAST_ADDR) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= prog_data;
        end
    end

    // Fetch pipeline: out-of-range addresses never touch unloaded words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_out_reg   <= '0;
            instr_valid_reg <= 1'b0;
            addr_err_reg    <= 1'b0;
        end else begin
            instr_valid_reg <= fetch_go;
            addr_err_reg    <= fetch_go && !fetch_hit;
            if (fetch_go) begin
                instr_out_reg <= fetch_hit ? mem[fetch_addr] : NOP_WORD;
            end
        end
    end

    assign instr_out   = instr_out_reg;
    assign instr_valid = instr_valid_reg;
    assign addr_err    = addr_err_reg;
    assign prog_count  = prog_count_reg;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: fetch expectations are queued by the
// stimulus and popped by a negedge monitor whenever instr_valid is seen.
module tb_instr_mem_loadable;

    localparam int               ROM_SIZE    = 32;
    localparam int               INSTR_WIDTH = 9;
    localparam int               ADDR_WIDTH  = 5;
    localparam logic [8:0]       NOP         = 9'h155;

    logic                   clk;
    logic                   rst_n;
    logic                   prog_valid;
    logic [INSTR_WIDTH-1:0] prog_data;
    logic                   prog_last;
    logic                   prog_ready;
    logic                   reload;
    logic                   fetch_en;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic                   instr_valid;
    logic                   addr_err;
    logic                   loaded;
    logic [ADDR_WIDTH:0]    prog_count;

    int checks = 0;
    int errors = 0;
    logic [INSTR_WIDTH:0] exp_q[$];

    instr_mem_loadable #(
        .ROM_SIZE   (ROM_SIZE),
        .INSTR_WIDTH(INSTR_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NOP_WORD   (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_last  (prog_last),
        .prog_ready (prog_ready),
        .reload     (reload),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .addr_err   (addr_err),
        .loaded     (loaded),
        .prog_count (prog_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] w(input int i, input int s);
        return 9'((i * 37 + s) % 512);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int start, input int n, input int seed, input bit use_last);
        for (int i = 0; i < n; i++) begin
            prog_valid = 1'b1;
            prog_data  = w(start + i, seed);
            prog_last  = use_last && (i == n - 1);
            tick();
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic fetch(input int a, input logic [8:0] d, input logic err);
        fetch_en   = 1'b1;
        fetch_addr = ADDR_WIDTH'(a);
        exp_q.push_back({err, d});
        tick();
    endtask

    task automatic idle();
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  32'(prog_ready),  1);
        chk({tag, "_loaded"}, 32'(loaded),      0);
        chk({tag, "_count"},  32'(prog_count),  0);
        chk({tag, "_out"},    32'(instr_out),   0);
        chk({tag, "_valid"},  32'(instr_valid), 0);
        chk({tag, "_err"},    32'(addr_err),    0);
    endtask

    // Monitor: every instr_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_fetch: got out=%0h err=%0b expected no response", instr_out, addr_err);
                end else begin
                    logic [INSTR_WIDTH:0] e;
                    e = exp_q.pop_front();
                    if ({addr_err, instr_out} !== e) begin
                        errors++;
                        $display("FAIL fetch_resp: got err=%0b out=%0h expected err=%0b out=%0h",
                                 addr_err, instr_out, e[INSTR_WIDTH], e[INSTR_WIDTH-1:0]);
                    end else begin
                        $display("ok   fetch_resp: err=%0b out=%0h", addr_err, instr_out);
                    end
                end
            end else if (addr_err) begin
                checks++;
                errors++;
                $display("FAIL stray_addr_err: got 1 expected 0 without instr_valid");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        prog_valid = 1'b0;
        prog_data  = '0;
        prog_last  = 1'b0;
        reload     = 1'b0;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        #12;
        chk_reset_vals("reset");
        tick();
        rst_n = 1'b1;

        // Fetch while loading is ignored
        fetch_en   = 1'b1;
        fetch_addr = '0;
        tick();
        chk("load_fetch_valid", 32'(instr_valid), 0);
        chk("load_fetch_out", 32'(instr_out), 0);
        fetch_en = 1'b0;

        // 19-word program
        load(0, 18, 5, 1'b0);
        chk("pre_last_loaded", 32'(loaded), 0);
        load(18, 1, 5, 1'b1);
        chk("load19_count", 32'(prog_count), 19);
        chk("load19_loaded", 32'(loaded), 1);
        chk("load19_ready", 32'(prog_ready), 0);

        fetch(0, w(0, 5), 1'b0);
        fetch(1, w(1, 5), 1'b0);
        fetch(18, w(18, 5), 1'b0);
        fetch(19, NOP, 1'b1);
        fetch(31, NOP, 1'b1);
        idle();
        chk("idle_valid", 32'(instr_valid), 0);
        chk("idle_hold", 32'(instr_out), 32'(NOP));

        // Program port ignored in run mode
        prog_valid = 1'b1;
        prog_data  = 9'h1FF;
        prog_last  = 1'b1;
        tick();
        tick();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        chk("run_ignore_count", 32'(prog_count), 19);
        fetch(19, NOP, 1'b1);
        fetch(18, w(18, 5), 1'b0);
        idle();

        // Reload beats a simultaneous fetch
        reload     = 1'b1;
        fetch_en   = 1'b1;
        fetch_addr = '0;
        tick();
        reload   = 1'b0;
        fetch_en = 1'b0;
        chk("reload_valid", 32'(instr_valid), 0);
        chk("reload_loaded", 32'(loaded), 0);
        chk("reload_ready", 32'(prog_ready), 1);
        chk("reload_count", 32'(prog_count), 0);

        // Reload held high while loading has no effect
        reload = 1'b1;
        load(0, 3, 100, 1'b1);
        reload = 1'b0;
        chk("load3_count", 32'(prog_count), 3);
        chk("load3_loaded", 32'(loaded), 1);
        fetch(0, w(0, 100), 1'b0);
        fetch(2, w(2, 100), 1'b0);
        fetch(3, NOP, 1'b1);
        idle();

        // Fill the whole memory without prog_last
        reload = 1'b1;
        tick();
        reload = 1'b0;
        load(0, ROM_SIZE - 1, 200, 1'b0);
        chk("full_m1_loaded", 32'(loaded), 0);
        chk("full_m1_count", 32'(prog_count), ROM_SIZE - 1);
        load(ROM_SIZE - 1, 1, 200, 1'b0);
        chk("full_loaded", 32'(loaded), 1);
        chk("full_count", 32'(prog_count), ROM_SIZE);
        prog_valid = 1'b1;
        prog_data  = 9'h0AA;
        tick();
        prog_valid = 1'b0;
        chk("full_extra_count", 32'(prog_count), ROM_SIZE);
        fetch(31, w(31, 200), 1'b0);
        fetch(0, w(0, 200), 1'b0);
        idle();

        // Asynchronous reset in the middle of a load
        reload = 1'b1;
        tick();
        reload = 1'b0;
        load(0, 5, 300, 1'b0);
        chk("midload_count", 32'(prog_count), 5);
        prog_valid = 1'b1;
        prog_data  = 9'h0F0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        prog_valid = 1'b0;
        rst_n      = 1'b1;
        load(0, 2, 400, 1'b1);
        chk("post_rst_count", 32'(prog_count), 2);
        fetch(0, w(0, 400), 1'b0);
        fetch(1, w(1, 400), 1'b0);
        fetch(2, NOP, 1'b1);
        idle();
        idle();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
